mdu_sched: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline. It owns the HI/LO registers and sequences multi-cycle mult/div operations issued from the E stage through a busy countdown. It also raises a stall request that the hazard unit ORs into its existing stall term, so the D-stage multiply/divide family is held while a result is pending.

---
 rtl/mdu_sched.sv | 152 +++++++++++++++
 tb/tb_mdu_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle mult/div via a busy countdown.
// Optional madd accumulate (op 7) is built only when MDU_MADD_EN is defined.
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
`endif

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  hi_nxt, lo_nxt;
  logic [W-1:0]  res_hi, res_lo, res_hi_nxt, res_lo_nxt;
  logic          start;

  // Shared datapath: products and quotients for the op currently in E
  logic [2*W-1:0] prod_s, prod_u;
  logic [W-1:0]   a_mag, b_mag, b_mag_nz, b_nz;
  logic [W-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic           b_zero;

  assign prod_u = {W'(0), src_a_E} * {W'(0), src_b_E};
  assign prod_s = {{W{src_a_E[W-1]}}, src_a_E} * {{W{src_b_E[W-1]}}, src_b_E};

  // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN, rem 0
  assign b_zero   = (src_b_E == W'(0));
  assign a_mag    = src_a_E[W-1] ? (W'(0) - src_a_E) : src_a_E;
  assign b_mag    = src_b_E[W-1] ? (W'(0) - src_b_E) : src_b_E;
  assign b_mag_nz = b_zero ? W'(1) : b_mag;
  assign b_nz     = b_zero ? W'(1) : src_b_E;
  assign q_mag    = a_mag / b_mag_nz;
  assign r_mag    = a_mag % b_mag_nz;
  assign q_s      = (src_a_E[W-1] ^ src_b_E[W-1]) ? (W'(0) - q_mag) : q_mag;
  assign r_s      = src_a_E[W-1] ? (W'(0) - r_mag) : r_mag;
  assign q_u      = src_a_E / b_nz;
  assign r_u      = src_a_E % b_nz;

  always_comb begin
    start = 1'b0;
    if (state == IDLE) begin
      case (md_op_E)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD:                            start = 1'b1;
`endif
        default:                            start = 1'b0;
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign stall_md = md_use_D & (busy | start);

  // Next-state and register updates
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = hi;
    lo_nxt     = lo;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    case (state)
      IDLE: begin
        case (md_op_E)
          OP_MULT: begin
            {res_hi_nxt, res_lo_nxt} = prod_s;
            cnt_nxt   = CW'(MULT_CYCLES);
            state_nxt = RUN;
          end
          OP_MULTU: begin
            {res_hi_nxt, res_lo_nxt} = prod_u;
            cnt_nxt   = CW'(MULT_CYCLES);
            state_nxt = RUN;
          end
          OP_DIV: begin
            // Divide by zero re-commits the current HI/LO after the busy period
            {res_hi_nxt, res_lo_nxt} = b_zero ? {hi, lo} : {r_s, q_s};
            cnt_nxt   = CW'(DIV_CYCLES);
            state_nxt = RUN;
          end
          OP_DIVU: begin
            {res_hi_nxt, res_lo_nxt} = b_zero ? {hi, lo} : {r_u, q_u};
            cnt_nxt   = CW'(DIV_CYCLES);
            state_nxt = RUN;
          end
`ifdef MDU_MADD_EN
          OP_MADD: begin
            {res_hi_nxt, res_lo_nxt} = {hi, lo} + prod_s;
            cnt_nxt   = CW'(MULT_CYCLES);
            state_nxt = RUN;
          end
`endif
          OP_MTHI: hi_nxt = src_a_E;
          OP_MTLO: lo_nxt = src_a_E;
          default: ;
        endcase
      end
      default: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_nxt    = res_hi;
          lo_nxt    = res_lo;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed, table-driven bench for mdu_sched: busy timing, stall, HI/LO results and reset corners.
module tb_mdu_sched;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op_E;
  logic [31:0] src_a_E, src_b_E;
  logic        md_use_D;
  logic [31:0] hi, lo;
  logic        busy, stall_md;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi, prev_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op_E(md_op_E), .src_a_E(src_a_E),
    .src_b_E(src_b_E), .md_use_D(md_use_D), .hi(hi), .lo(lo),
    .busy(busy), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one op in E at cycle t, then follow it through t+N+1
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    md_op_E = v.op; src_a_E = v.a; src_b_E = v.b; md_use_D = v.use_d;
    #1;
    check("stall_issue", 64'(stall_md), 64'(v.use_d & (v.n > 0)));
    for (int i = 1; i <= v.n; i++) begin
      @(negedge clk);
      md_op_E = 4'd0;
      #1;
      check("busy_run", 64'(busy), 64'd1);
      check("stall_run", 64'(stall_md), 64'(v.use_d));
      check("hilo_hold", {hi, lo}, {prev_hi, prev_lo});
    end
    @(negedge clk);
    md_op_E = 4'd0;
    #1;
    check("busy_done", 64'(busy), 64'd0);
    check("stall_done", 64'(stall_md), 64'd0);
    check("hi_result", 64'(hi), 64'(v.hi));
    check("lo_result", 64'(lo), 64'(v.lo));
    md_use_D = 1'b0;
    prev_hi = v.hi;
    prev_lo = v.lo;
  endtask

  initial begin
    vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'h2,        1'b1, MC, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'h2,        1'b0, MC, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        1'b0, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'd4, 32'd100,      32'd7,        1'b0, DC, 32'h2,        32'hE};
    vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, DC, 32'h0,        32'h80000000};
    vecs[5]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 1'b0, DC, 32'h1,        32'hFFFFFFFD};
    vecs[6]  = '{4'd1, 32'h10000,    32'h10000,    1'b0, MC, 32'h1,        32'h0};
    vecs[7]  = '{4'd4, 32'hFFFFFFFF, 32'h10,       1'b0, DC, 32'hF,        32'h0FFFFFFF};
    vecs[8]  = '{4'd5, 32'h11,       32'h0,        1'b1, 0,  32'h11,       32'h0FFFFFFF};
    vecs[9]  = '{4'd6, 32'h22,       32'h0,        1'b0, 0,  32'h11,       32'h22};
    vecs[10] = '{4'd4, 32'd5,        32'd0,        1'b0, DC, 32'h11,       32'h22};
`ifdef MDU_MADD_EN
    vecs[11] = '{4'd7, 32'd2,        32'd3,        1'b1, MC, 32'h11,       32'h28};
`else
    vecs[11] = '{4'd7, 32'd2,        32'd3,        1'b1, 0,  32'h11,       32'h22};
`endif

    reset = 1'b1; md_op_E = 4'd0; src_a_E = '0; src_b_E = '0; md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall_md), 64'd0);
    reset = 1'b0;
    prev_hi = 32'h0;
    prev_lo = 32'h0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset at cycle 3 of a div aborts it; a mult at cycle 5 completes at cycle 11
    @(negedge clk);
    md_op_E = 4'd3; src_a_E = 32'd100; src_b_E = 32'd7;
    @(negedge clk); md_op_E = 4'd0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("abort_busy_c3", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    check("abort_busy_c4", 64'(busy), 64'd0);
    check("abort_hilo_c4", {hi, lo}, 64'd0);
    reset = 1'b0;
    prev_hi = 32'h0;
    prev_lo = 32'h0;
    run_vec('{4'd1, 32'd3, 32'd4, 1'b1, MC, 32'h0, 32'd12});

    // Simultaneous reset and start: reset wins, nothing latched
    @(negedge clk);
    reset = 1'b1; md_op_E = 4'd1; src_a_E = 32'd3; src_b_E = 32'd5;
    @(negedge clk);
    reset = 1'b0; md_op_E = 4'd0;
    #1;
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_hilo", {hi, lo}, 64'd0);
    repeat (MC + 1) @(negedge clk);
    #1;
    check("rst_start_idle", {31'd0, busy, hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
